snn_timestep_scheduler: RTL and testbench
=========================================

# snn_timestep_scheduler

Sequencing controller for the time-multiplexed spiking core. It accepts one 16-bit input spike frame per timestep and walks a single shared LIF neuron engine over every hidden neuron, collecting their spike bits. It then walks the output-layer accumulator over every command neuron and counts timesteps within an inference window. It sits between the spike-encoding front end and the neuron engine / output accumulator.

## Interface
- N_IN, 16, input spike channels per frame
- N_HIDDEN, 8, hidden neurons served by the shared engine
- N_OUT, 10, command (output) neurons
- T_STEPS, 32, timesteps per inference window
- WD_LIMIT, 15, max idle cycles waiting for an engine return before abort

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- input_spikes  in  N_IN  spike frame from encoder
- spike_valid  in  1  frame valid
- spike_ready  out  1  scheduler can accept a frame
- frame_spikes  out  N_IN  latched frame, stable from accept until frame_done
- hid_en  out  1  issue one hidden-neuron update to engine
- hid_addr  out  clog2(N_HIDDEN)  neuron index of issued update
- hid_spike  in  1  engine result spike bit
- hid_spike_valid  in  1  engine result valid; returns arrive in issue order
- out_en  out  1  issue one output-neuron accumulate
- out_addr  out  clog2(N_OUT)  output neuron index
- hidden_spikes  out  N_HIDDEN  hidden spike vector of last completed timestep
- state_clear  out  1  one-cycle pulse: engine and accumulator clear membranes
- frame_done  out  1  one-cycle pulse: timestep complete
- window_done  out  1  one-cycle pulse coincident with frame_done of last timestep
- timestep  out  clog2(T_STEPS)  index of the current/next timestep
- wd_err  out  1  sticky: engine watchdog fired; cleared only by reset

## Operation
- States: IDLE, HISSUE, HWAIT, OISSUE, DONE.
- IDLE: spike_ready=1. On spike_valid&spike_ready: latch input_spikes into frame_spikes, clear return counter and scratch vector, go to HISSUE with issue index 0.
- HISSUE: hid_en=1, hid_addr=index, one issue per cycle for indices 0..N_HIDDEN-1. After the last issue, go to HWAIT.
- Returns: each hid_spike_valid writes hid_spike into scratch[ret_cnt] and increments ret_cnt. Returns are accepted in both HISSUE and HWAIT, including in the same cycle as an issue. hid_spike_valid is ignored in every other state.
- HWAIT: when ret_cnt reaches N_HIDDEN (including a return landing in this cycle), go to OISSUE with index 0. The watchdog counter resets on each return. If it reaches WD_LIMIT, set wd_err, zero the unreturned scratch bits, and go to DONE.
- OISSUE: out_en=1, out_addr=0..N_OUT-1, one per cycle. hidden_spikes is updated from scratch on entry to OISSUE, so the accumulator sees the current vector. After the last issue, go to DONE.
- DONE: one cycle. Pulse frame_done, then:
  - if timestep==T_STEPS-1: also pulse window_done and state_clear, and wrap timestep to 0;
  - otherwise increment timestep.
  - Go to IDLE.
- Frames offered while not in IDLE are held upstream (spike_ready=0); no frame is ever dropped or overwritten.
- Reset mid-operation: all state is discarded, and the next frame starts at timestep 0.

## Timing
- Reset values:
  - spike_ready=0 during reset, 1 in the first cycle after release;
  - all other outputs 0, and state is IDLE.
- Accept at edge k puts the state in HISSUE during cycle k+1. Issues occupy k+1..k+N_HIDDEN.
- With engine latency L (cycles from issue to return), the last return arrives at k+N_HIDDEN+L. OISSUE covers the following N_OUT cycles. DONE comes next.
- Total frame latency is N_HIDDEN+L+N_OUT+2 cycles from accept to frame_done. With L=2 and the default parameters, that is 22 cycles.
- spike_ready rises in the cycle after DONE, so back-to-back frames have a one-cycle IDLE gap.
- frame_spikes and hidden_spikes are stable between their update points.

## Test plan
- Single frame, engine L=2 returning bit = addr[0]: frame 16'hA5A5 is accepted, hid_addr walks 0..7, and hidden_spikes=8'hAA. out_addr walks 0..9, frame_done fires 22 cycles after accept, and timestep=1.
- Back-to-back frames (spike_valid held high for 3 frames): exactly 3 accepts occur, spike_ready is low between accept and DONE, and each frame is latched unmodified.
- Window wrap with T_STEPS=4 over 4 frames: window_done and state_clear pulse together with the 4th frame_done, and timestep returns to 0.
- Engine L=0, with returns in the same cycle as issues: all 8 bits are captured correctly and the state passes from HISSUE through HWAIT to OISSUE without losing a return.
- Engine stalls after 5 returns: wd_err sets after WD_LIMIT cycles, hidden_spikes[7:5]=0, frame_done pulses, and the next frame is accepted normally with wd_err still 1.
- reset_n asserted during HWAIT: all outputs go to 0 immediately. After release, the next frame restarts at timestep 0 with hid_addr from 0.

Source files
------------

// File: rtl/snn_timestep_scheduler_if.sv
// Spike-frame handshake, engine issue/return and status bundle for the
// timestep scheduler; slave = scheduler side, master = environment side.
interface snn_timestep_scheduler_if #(
  parameter int N_IN     = 16,
  parameter int N_HIDDEN = 8,
  parameter int N_OUT    = 10,
  parameter int T_STEPS  = 32
);
  localparam int HAW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int TW  = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

  logic [N_IN-1:0]     input_spikes;
  logic                spike_valid;
  logic                spike_ready;
  logic [N_IN-1:0]     frame_spikes;
  logic                hid_en;
  logic [HAW-1:0]      hid_addr;
  logic                hid_spike;
  logic                hid_spike_valid;
  logic                out_en;
  logic [OAW-1:0]      out_addr;
  logic [N_HIDDEN-1:0] hidden_spikes;
  logic                state_clear;
  logic                frame_done;
  logic                window_done;
  logic [TW-1:0]       timestep;
  logic                wd_err;

  modport slave (
    input  input_spikes, spike_valid, hid_spike, hid_spike_valid,
    output spike_ready, frame_spikes, hid_en, hid_addr,
    output out_en, out_addr, hidden_spikes, state_clear,
    output frame_done, window_done, timestep, wd_err
  );

  modport master (
    output input_spikes, spike_valid, hid_spike, hid_spike_valid,
    input  spike_ready, frame_spikes, hid_en, hid_addr,
    input  out_en, out_addr, hidden_spikes, state_clear,
    input  frame_done, window_done, timestep, wd_err
  );
endinterface

// File: rtl/snn_timestep_scheduler.sv
// Timestep scheduler: latches a spike frame, walks the shared LIF engine
// over all hidden neurons, then the output accumulator, and tracks timesteps.
// Ports: clk, reset_n (async, active low), bus (snn_timestep_scheduler_if.slave).
module snn_timestep_scheduler #(
  parameter int N_IN     = 16,
  parameter int N_HIDDEN = 8,
  parameter int N_OUT    = 10,
  parameter int T_STEPS  = 32,
  parameter int WD_LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  snn_timestep_scheduler_if.slave bus
);
  localparam int HAW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int TW  = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam int RCW = $clog2(N_HIDDEN + 1);
  localparam int WDW = $clog2(WD_LIMIT + 1);

  localparam logic [HAW-1:0] H_LAST  = HAW'(N_HIDDEN - 1);
  localparam logic [OAW-1:0] O_LAST  = OAW'(N_OUT - 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(T_STEPS - 1);
  localparam logic [RCW-1:0] NH_C    = RCW'(N_HIDDEN);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HISSUE, S_HWAIT, S_OISSUE, S_DONE
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic [N_IN-1:0]     r_frame;
  logic                r_hid_en;
  logic [HAW-1:0]      r_hid_addr;
  logic                r_out_en;
  logic [OAW-1:0]      r_out_addr;
  logic [N_HIDDEN-1:0] r_scratch;
  logic [N_HIDDEN-1:0] r_hidden;
  logic [RCW-1:0]      r_ret_cnt;
  logic [WDW-1:0]      r_wd_cnt;
  logic [TW-1:0]       r_ts;
  logic                r_clear;
  logic                r_fdone;
  logic                r_wdone;
  logic                r_wd_err;

  logic                w_ret;
  logic [HAW-1:0]      w_ret_idx;
  logic [RCW-1:0]      w_cnt_nx;
  logic                w_all;
  logic [N_HIDDEN-1:0] w_scratch;

  // Returns only count while the engine walk is in flight; surplus ones
  // beyond N_HIDDEN are ignored so the scratch index stays in range.
  assign w_ret = bus.hid_spike_valid
               & ((r_state == S_HISSUE) | (r_state == S_HWAIT))
               & (r_ret_cnt < NH_C);
  assign w_ret_idx = r_ret_cnt[HAW-1:0];
  assign w_cnt_nx  = r_ret_cnt + RCW'(w_ret);
  assign w_all     = (w_cnt_nx == NH_C);

  // Scratch including a return landing this cycle.
  always_comb begin
    w_scratch = r_scratch;
    if (w_ret) w_scratch[w_ret_idx] = bus.hid_spike;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_frame    <= '0;
      r_hid_en   <= 1'b0;
      r_hid_addr <= '0;
      r_out_en   <= 1'b0;
      r_out_addr <= '0;
      r_scratch  <= '0;
      r_hidden   <= '0;
      r_ret_cnt  <= '0;
      r_wd_cnt   <= '0;
      r_ts       <= '0;
      r_clear    <= 1'b0;
      r_fdone    <= 1'b0;
      r_wdone    <= 1'b0;
      r_wd_err   <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_fdone <= 1'b0;
      r_wdone <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // First cycle out of reset only raises ready.
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (bus.spike_valid) begin
            r_ready    <= 1'b0;
            r_frame    <= bus.input_spikes;
            r_scratch  <= '0;
            r_ret_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_hid_en   <= 1'b1;
            r_hid_addr <= '0;
            r_state    <= S_HISSUE;
          end
        end
        S_HISSUE: begin
          r_scratch <= w_scratch;
          r_ret_cnt <= w_cnt_nx;
          if (w_ret) r_wd_cnt <= '0;
          if (r_hid_addr == H_LAST) begin
            r_hid_en <= 1'b0;
            r_state  <= S_HWAIT;
          end else begin
            r_hid_addr <= r_hid_addr + HAW'(1);
          end
        end
        S_HWAIT: begin
          r_scratch <= w_scratch;
          r_ret_cnt <= w_cnt_nx;
          if (w_all) begin
            r_hidden   <= w_scratch;
            r_out_en   <= 1'b1;
            r_out_addr <= '0;
            r_state    <= S_OISSUE;
          end else if (w_ret) begin
            r_wd_cnt <= '0;
          end else if (r_wd_cnt == WD_LAST) begin
            // Unreturned bits are still zero from the clear at accept.
            r_wd_err <= 1'b1;
            r_hidden <= w_scratch;
            r_state  <= S_DONE;
          end else begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
        end
        S_OISSUE: begin
          if (r_out_addr == O_LAST) begin
            r_out_en <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_out_addr <= r_out_addr + OAW'(1);
          end
        end
        S_DONE: begin
          r_fdone <= 1'b1;
          r_ready <= 1'b1;
          if (r_ts == T_LAST) begin
            r_wdone <= 1'b1;
            r_clear <= 1'b1;
            r_ts    <= '0;
          end else begin
            r_ts <= r_ts + TW'(1);
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.spike_ready   = r_ready;
  assign bus.frame_spikes  = r_frame;
  assign bus.hid_en        = r_hid_en;
  assign bus.hid_addr      = r_hid_addr;
  assign bus.out_en        = r_out_en;
  assign bus.out_addr      = r_out_addr;
  assign bus.hidden_spikes = r_hidden;
  assign bus.state_clear   = r_clear;
  assign bus.frame_done    = r_fdone;
  assign bus.window_done   = r_wdone;
  assign bus.timestep      = r_ts;
  assign bus.wd_err        = r_wd_err;
endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler: timeline model of each
// frame plus an engine model with configurable latency and stall point.
module tb_snn_timestep_scheduler;
  localparam int N_IN     = 16;
  localparam int N_HIDDEN = 8;
  localparam int N_OUT    = 10;
  localparam int T_STEPS  = 4;
  localparam int WD_LIMIT = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  snn_timestep_scheduler_if #(
    .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_OUT(N_OUT), .T_STEPS(T_STEPS)
  ) bus ();

  snn_timestep_scheduler #(
    .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_OUT(N_OUT),
    .T_STEPS(T_STEPS), .WD_LIMIT(WD_LIMIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model configuration
  int eng_L = 2;
  int eng_stall = 8;
  logic eng_inv = 1'b0;
  typedef struct { int due; int addr; } ret_t;
  ret_t q[$];

  // frame timeline model
  bit m_busy, m_rdy_ok, m_werr, m_wset;
  int m_A, m_hup, m_F, m_ts;
  logic [15:0] m_frame, m_fnew;
  logic [7:0]  m_hidden, m_hnew;

  // DUT observations used by directed checks
  int dacc = 0, dfd = 0, dlast_acc = 0, dlast_fd = 0, wcnt = 0, wbad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] outs_now();
    return {bus.spike_ready, bus.frame_spikes, bus.hid_en, bus.hid_addr,
            bus.out_en, bus.out_addr, bus.hidden_spikes, bus.state_clear,
            bus.frame_done, bus.window_done, bus.timestep, bus.wd_err};
  endfunction

  task automatic model_accept(input int c);
    int r, ex, rl, s;
    r = (eng_stall < N_HIDDEN) ? eng_stall : N_HIDDEN;
    m_hnew = '0;
    for (int i = 0; i < r; i++) m_hnew[i] = (i % 2 == 1) ^ eng_inv;
    m_fnew = bus.input_spikes;
    m_A = c;
    m_busy = 1'b1;
    if (r == N_HIDDEN) begin
      // last return lands at c+8+L, but HWAIT always takes one cycle
      ex = c + N_HIDDEN + eng_L;
      if (ex < c + N_HIDDEN + 1) ex = c + N_HIDDEN + 1;
      m_hup = ex + 1;
      m_F = ex + N_OUT + 2;
      m_wset = 1'b0;
    end else begin
      rl = (r == 0) ? c : c + r + eng_L;
      s = (rl + 1 > c + N_HIDDEN + 1) ? rl + 1 : c + N_HIDDEN + 1;
      m_hup = s + WD_LIMIT;
      m_F = s + WD_LIMIT + 1;
      m_wset = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    int c;
    bit e_hen, e_oen, e_fd, e_win, e_rdy;
    logic [2:0] e_ha, a_ha;
    logic [3:0] e_oa, a_oa;
    logic [39:0] act, exp;
    c = cyc;
    if (!reset_n) begin
      m_busy = 0; m_rdy_ok = 0; m_werr = 0; m_ts = 0;
      m_frame = '0; m_hidden = '0;
      q.delete();
      bus.hid_spike_valid = 1'b0;
      bus.hid_spike = 1'b0;
    end else begin
      e_hen = m_busy && c >= m_A + 1 && c <= m_A + N_HIDDEN;
      e_ha = e_hen ? 3'(c - m_A - 1) : 3'd0;
      e_oen = m_busy && !m_wset && c >= m_hup && c <= m_hup + N_OUT - 1;
      e_oa = e_oen ? 4'(c - m_hup) : 4'd0;
      if (m_busy && c == m_A + 1) m_frame = m_fnew;
      if (m_busy && c == m_hup) begin
        m_hidden = m_hnew;
        if (m_wset) m_werr = 1'b1;
      end
      e_fd = m_busy && c == m_F;
      e_win = 1'b0;
      if (e_fd) begin
        e_win = (m_ts == T_STEPS - 1);
        m_ts = (m_ts + 1) % T_STEPS;
        m_busy = 1'b0;
      end
      e_rdy = m_busy ? 1'b0 : m_rdy_ok;
      a_ha = e_hen ? bus.hid_addr : 3'd0;
      a_oa = e_oen ? bus.out_addr : 4'd0;
      act = {bus.spike_ready, bus.frame_spikes, bus.hid_en, a_ha,
             bus.out_en, a_oa, bus.hidden_spikes, bus.state_clear,
             bus.frame_done, bus.window_done, bus.timestep, bus.wd_err};
      exp = {e_rdy, m_frame, e_hen, e_ha, e_oen, e_oa, m_hidden, e_win,
             e_fd, e_win, 2'(m_ts), m_werr};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL cycle_%0d outputs actual=%h expected=%h", c, act, exp);
      end
      m_rdy_ok = 1'b1;
      if (e_rdy && bus.spike_valid) model_accept(c);

      if (bus.spike_valid && bus.spike_ready) begin
        dacc++; dlast_acc = c;
      end
      if (bus.frame_done) begin
        dfd++; dlast_fd = c;
      end
      if (bus.window_done) begin
        wcnt++;
        if (!(bus.frame_done && bus.state_clear)) wbad++;
      end

      if (bus.hid_en && int'(bus.hid_addr) < eng_stall)
        q.push_back('{due: c + eng_L, addr: int'(bus.hid_addr)});
      bus.hid_spike_valid = 1'b0;
      bus.hid_spike = 1'b0;
      if (q.size() > 0 && q[0].due == c) begin
        bus.hid_spike_valid = 1'b1;
        bus.hid_spike = (q[0].addr % 2 == 1) ^ eng_inv;
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] f, input bit keep);
    int n0;
    n0 = dacc;
    bus.input_spikes = f;
    bus.spike_valid = 1'b1;
    for (int i = 0; i < 60 && dacc == n0; i++) begin
      @(posedge clk); #2;
    end
    chk("accept_timeout", 64'(dacc != n0), 64'd1);
    if (!keep) bus.spike_valid = 1'b0;
  endtask

  task automatic wait_fd(input int bound);
    int n0;
    n0 = dfd;
    for (int i = 0; i < bound && dfd == n0; i++) begin
      @(posedge clk); #2;
    end
    chk("frame_done_timeout", 64'(dfd != n0), 64'd1);
  endtask

  initial begin
    int a0, tgt;
    bus.input_spikes = '0;
    bus.spike_valid = 1'b0;
    bus.hid_spike = 1'b0;
    bus.hid_spike_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(outs_now()), 64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_release", 64'(bus.spike_ready), 64'd1);

    // single frame, L=2, bit = addr[0]
    eng_L = 2; eng_stall = 8; eng_inv = 1'b0;
    send(16'hA5A5, 1'b0);
    wait_fd(60);
    chk("t1_latency", 64'(dlast_fd - dlast_acc), 64'd22);
    chk("t1_hidden", 64'(bus.hidden_spikes), 64'hAA);
    chk("t1_timestep", 64'(bus.timestep), 64'd1);
    chk("t1_frame", 64'(bus.frame_spikes), 64'hA5A5);

    // back-to-back frames; the third completes the 4-step window
    a0 = dacc;
    send(16'h1234, 1'b1);
    send(16'hBEEF, 1'b1);
    send(16'h0F0F, 1'b0);
    wait_fd(60);
    repeat (3) @(posedge clk);
    #2;
    chk("b2b_accepts", 64'(dacc - a0), 64'd3);
    chk("b2b_frame", 64'(bus.frame_spikes), 64'h0F0F);
    chk("window_pulses", 64'(wcnt), 64'd1);
    chk("window_coincident", 64'(wbad), 64'd0);
    chk("wrap_timestep", 64'(bus.timestep), 64'd0);

    // zero-latency engine, inverted bits
    eng_L = 0; eng_inv = 1'b1;
    send(16'h00FF, 1'b0);
    wait_fd(60);
    chk("l0_hidden", 64'(bus.hidden_spikes), 64'h55);

    // engine stalls after five returns
    eng_L = 2; eng_stall = 5; eng_inv = 1'b0;
    send(16'h8001, 1'b0);
    wait_fd(80);
    chk("wd_err_set", 64'(bus.wd_err), 64'd1);
    chk("wd_hidden", 64'(bus.hidden_spikes), 64'h0A);
    chk("wd_hidden_top", 64'(bus.hidden_spikes[7:5]), 64'd0);
    chk("wd_latency", 64'(dlast_fd - dlast_acc), 64'd25);
    eng_stall = 8;
    send(16'h7E7E, 1'b0);
    wait_fd(60);
    chk("wd_sticky", 64'(bus.wd_err), 64'd1);
    chk("post_wd_hidden", 64'(bus.hidden_spikes), 64'hAA);
    chk("post_wd_latency", 64'(dlast_fd - dlast_acc), 64'd22);

    // reset while waiting on engine returns
    eng_L = 6;
    send(16'h3C3C, 1'b0);
    tgt = dlast_acc + 10;
    for (int i = 0; i < 40 && cyc != tgt; i++) begin
      @(posedge clk); #2;
    end
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'(outs_now()), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    eng_L = 2;
    send(16'h1111, 1'b0);
    chk("rst_ts_zero", 64'(bus.timestep), 64'd0);
    chk("rst_first_issue", 64'({bus.hid_en, bus.hid_addr}), 64'h8);
    wait_fd(60);
    chk("rst_ts_next", 64'(bus.timestep), 64'd1);
    chk("rst_hidden", 64'(bus.hidden_spikes), 64'hAA);
    chk("rst_wd_cleared", 64'(bus.wd_err), 64'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
